// File: rtl/uart_msg_pkg.sv
// Shared constants for the UART message arbiter: FSM encoding, framing characters and
// the indices of the message sources.
package uart_msg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_SEND = 3'd2;
    localparam state_t ST_WAIT = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam logic [7:0] TERM_CHAR = 8'h23;
    localparam logic [7:0] CR_CHAR   = 8'h0D;

    localparam int unsigned DEFAULT_MSG_LEN = 12;

    localparam int unsigned SRC_COLOR  = 0;
    localparam int unsigned SRC_PICK   = 1;
    localparam int unsigned SRC_DEPOSE = 2;
    localparam int unsigned SRC_SPARE  = 3;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first set bit of pending, searching upward from start
// and wrapping at NUM_REQ-1.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IW-1:0]      start,
    output logic               valid,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      index
);

    int unsigned j;

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        index  = '0;
        j      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(start) + k) % NUM_REQ;
            if (!valid && pending[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                index     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between NUM_REQ message sources: captures request edges,
// grants round-robin and streams the latched message byte-by-byte up to the '#' terminator.
module uart_tx_arbiter
    import uart_msg_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MSG_LEN     = DEFAULT_MSG_LEN,
    parameter bit          APPEND_CR   = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*MSG_LEN*8-1:0] msg_data,
    input  logic                       tx_done,
    output logic                       tx_data_valid,
    output logic [7:0]                 tx_byte,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         msg_sent,
    output logic                       tx_err
);

    localparam int unsigned MSG_BITS = MSG_LEN * 8;
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [NUM_REQ-1:0]   req_q;
    logic [IW-1:0]        rr_q, rr_d;
    logic [IW-1:0]        gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [MSG_BITS-1:0]  buf_q, buf_d;
    logic [BW-1:0]        byte_idx_q, byte_idx_d;
    logic                 cr_q, cr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7:0]           tx_byte_q, tx_byte_d;

    logic                 pick_valid;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IW-1:0]        pick_index;
    logic [NUM_REQ-1:0]   req_rise;
    logic [MSG_BITS-1:0]  src_msg;
    logic [IW-1:0]        rr_next;
    logic                 last_byte;
    logic                 tmo_hit;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .pending (pending_q),
        .start   (rr_q),
        .valid   (pick_valid),
        .onehot  (pick_onehot),
        .index   (pick_index)
    );

    assign req_rise  = req & ~req_q;
    assign src_msg   = msg_data[32'(gnt_idx_q) * MSG_BITS +: MSG_BITS];
    assign rr_next   = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
    assign last_byte = (byte_idx_q == BW'(MSG_LEN - 1));
    // tx_done wins over a timeout that would expire in the same cycle.
    assign tmo_hit   = (state_q == ST_WAIT) && !tx_done && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        rr_d       = rr_q;
        gnt_idx_d  = gnt_idx_q;
        grant_d    = grant_q;
        buf_d      = buf_q;
        byte_idx_d = byte_idx_q;
        cr_d       = cr_q;
        cnt_d      = cnt_q;
        tx_byte_d  = tx_byte_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_idx_d = pick_index;
                    grant_d   = pick_onehot;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Byte 0 comes straight from the input slice since the buffer loads on this edge.
                buf_d      = src_msg;
                byte_idx_d = '0;
                cr_d       = 1'b0;
                tx_byte_d  = src_msg[MSG_BITS-1 -: 8];
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (cr_q) begin
                        state_d = ST_DONE;
                    end else if (tx_byte_q == TERM_CHAR || last_byte) begin
                        if (APPEND_CR) begin
                            cr_d      = 1'b1;
                            tx_byte_d = CR_CHAR;
                            state_d   = ST_SEND;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        tx_byte_d  = buf_q[(MSG_LEN - 2 - 32'(byte_idx_q)) * 8 +: 8];
                        state_d    = ST_SEND;
                    end
                end else if (tmo_hit) begin
                    pending_d[gnt_idx_q] = 1'b0;
                    rr_d                 = rr_next;
                    grant_d              = '0;
                    state_d              = ST_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                pending_d[gnt_idx_q] = 1'b0;
                rr_d                 = rr_next;
                grant_d              = '0;
                state_d              = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new request edge overrides the clear in DONE or on timeout.
        pending_d = pending_d | req_rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            req_q      <= '0;
            rr_q       <= '0;
            gnt_idx_q  <= '0;
            grant_q    <= '0;
            buf_q      <= '0;
            byte_idx_q <= '0;
            cr_q       <= 1'b0;
            cnt_q      <= '0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            req_q      <= req;
            rr_q       <= rr_d;
            gnt_idx_q  <= gnt_idx_d;
            grant_q    <= grant_d;
            buf_q      <= buf_d;
            byte_idx_q <= byte_idx_d;
            cr_q       <= cr_d;
            cnt_q      <= cnt_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign tx_data_valid = (state_q == ST_SEND);
    assign tx_byte       = tx_byte_q;
    assign grant         = grant_q;
    assign busy          = (state_q != ST_IDLE);
    assign msg_sent      = (state_q == ST_DONE) ? grant_q : '0;
    assign tx_err        = tmo_hit;

endmodule
